// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, flag indices and FSM states for the ALU command sequencer
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_INC = 4'd7;
   localparam logic [3:0] OP_DEC = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_MAX = 4'd9;

   localparam int FLG_ERR = 4;
   localparam int FLG_C   = 3;
   localparam int FLG_Z   = 2;
   localparam int FLG_S   = 1;
   localparam int FLG_P   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
module alu_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   // full is judged on the current count, so a pop never makes room for a same-cycle push
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues tagged ALU commands, drives the registered ALU, returns tagged results
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N       = 16,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int ALU_LAT = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_opcode,
   input  logic [N-1:0]           cmd_a,
   input  logic [N-1:0]           cmd_b,
   input  logic [TAG_W-1:0]       cmd_tag,
   output logic                   alu_start,
   output logic [3:0]             alu_opcode,
   output logic [N-1:0]           alu_a,
   output logic [N-1:0]           alu_b,
   input  logic [N-1:0]           alu_y,
   input  logic                   alu_cflag,
   input  logic                   alu_zflag,
   input  logic                   alu_sflag,
   input  logic                   alu_pflag,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [N-1:0]           rsp_y,
   output logic [4:0]             rsp_flags,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int FW    = 4 + 2 * N + TAG_W;
   localparam int CNT_W = $clog2(ALU_LAT);

   logic [FW-1:0]    fifo_wdata;
   logic [FW-1:0]    fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [3:0]       head_op;
   logic [N-1:0]     head_a;
   logic [N-1:0]     head_b;
   logic [TAG_W-1:0] head_tag;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alu_start_q, alu_start_d;
   logic [3:0]       alu_opcode_q, alu_opcode_d;
   logic [N-1:0]     alu_a_q, alu_a_d;
   logic [N-1:0]     alu_b_q, alu_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [N-1:0]     rsp_y_q, rsp_y_d;
   logic [4:0]       rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_tag};
   assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

   alu_cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (cmd_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign cmd_ready  = !fifo_full;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;
   assign alu_start  = alu_start_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_y      = rsp_y_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_tag    = rsp_tag_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fifo_pop     = 1'b0;
      alu_start_d  = alu_start_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_y_d      = rsp_y_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_tag_d    = rsp_tag_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               rsp_tag_d = head_tag;
               if (head_op <= OP_MAX) begin
                  alu_start_d  = 1'b1;
                  alu_opcode_d = head_op;
                  alu_a_d      = head_a;
                  alu_b_d      = head_b;
                  cnt_d        = CNT_W'(ALU_LAT - 1);
                  state_d      = ST_ISSUE;
               end else begin
                  // unsupported opcode: answer with the error flag, the ALU is never started
                  rsp_y_d              = '0;
                  rsp_flags_d          = '0;
                  rsp_flags_d[FLG_ERR] = 1'b1;
                  rsp_valid_d          = 1'b1;
                  state_d              = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            if (cnt_q == '0) begin
               rsp_y_d            = alu_y;
               rsp_flags_d        = '0;
               rsp_flags_d[FLG_C] = alu_cflag;
               rsp_flags_d[FLG_Z] = alu_zflag;
               rsp_flags_d[FLG_S] = alu_sflag;
               rsp_flags_d[FLG_P] = alu_pflag;
               alu_start_d        = 1'b0;
               rsp_valid_d        = 1'b1;
               state_d            = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            // passing back through IDLE guarantees the ALU sees start low before the next issue
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_start_q  <= 1'b0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_y_q      <= '0;
         rsp_flags_q  <= '0;
         rsp_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_start_q  <= alu_start_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_y_q      <= rsp_y_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with a registered ALU model
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   localparam int N       = 16;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int ALU_LAT = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_opcode = '0;
   logic [N-1:0]     cmd_a = '0;
   logic [N-1:0]     cmd_b = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic             alu_start;
   logic [3:0]       alu_opcode;
   logic [N-1:0]     alu_a;
   logic [N-1:0]     alu_b;
   logic [N-1:0]     alu_y;
   logic             alu_cflag = 1'b0;
   logic             alu_zflag = 1'b0;
   logic             alu_sflag = 1'b0;
   logic             alu_pflag = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [N-1:0]     rsp_y;
   logic [4:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic [$clog2(DEPTH):0] fifo_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .N (N), .DEPTH (DEPTH), .TAG_W (TAG_W), .ALU_LAT (ALU_LAT)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_opcode (cmd_opcode),
      .cmd_a (cmd_a), .cmd_b (cmd_b), .cmd_tag (cmd_tag),
      .alu_start (alu_start), .alu_opcode (alu_opcode), .alu_a (alu_a), .alu_b (alu_b),
      .alu_y (alu_y), .alu_cflag (alu_cflag), .alu_zflag (alu_zflag),
      .alu_sflag (alu_sflag), .alu_pflag (alu_pflag),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_y (rsp_y),
      .rsp_flags (rsp_flags), .rsp_tag (rsp_tag),
      .busy (busy), .fifo_count (fifo_count)
   );

   // registered ALU: result one cycle after start, flags one cycle after the result
   logic [N-1:0] m_y = '0;
   logic         m_cp = 1'b0;
   assign alu_y = m_y;

   function automatic logic [N:0] alu_model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_SHL:  return {1'b0, a << 1};
         OP_SHR:  return {1'b0, a >> 1};
         OP_INC:  return {1'b0, a + 16'd1};
         OP_DEC:  return {1'b0, a - 16'd1};
         OP_NOT:  return {1'b0, ~a};
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (alu_start) {m_cp, m_y} <= alu_model(alu_opcode, alu_a, alu_b);
      alu_cflag <= m_cp;
      alu_zflag <= (m_y == '0);
      alu_sflag <= m_y[N-1];
      alu_pflag <= ^m_y;
   end

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  tag;
      logic [15:0] y;
      logic [4:0]  fl;
   } vec_t;

   vec_t vecs[7];

   logic [3:0]  sq_op[16];
   logic [15:0] sq_a[16];
   logic [15:0] sq_b[16];
   logic [15:0] sq_y[16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
      int n = 0;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_tag    = tag;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_stream(input int cnt);
      int   got = 0;
      int   rises = 0;
      int   last_rise = 0;
      logic prev;
      rsp_ready = 1'b1;
      prev = alu_start;
      fork
         begin
            for (int i = 0; i < cnt; i++) push(sq_op[i], sq_a[i], sq_b[i], 4'(i));
         end
         begin
            for (int c = 0; c < 150; c++) begin
               @(negedge clk);
               if (alu_start && !prev) begin
                  if (rises > 0) chk("issue_spacing", 32'(c - last_rise), 32'(ALU_LAT + 2));
                  rises++;
                  last_rise = c;
               end
               prev = alu_start;
               if (rsp_valid) begin
                  if (got < cnt) begin
                     chk("stream_tag", 32'(rsp_tag), 32'(got % 16));
                     chk("stream_y", 32'(rsp_y), 32'(sq_y[got]));
                  end
                  got++;
               end
            end
         end
      join
      chk("stream_count", 32'(got), 32'(cnt));
      chk("stream_issues", 32'(rises), 32'(cnt));
      rsp_ready = 1'b0;
   endtask

   initial begin
      int starts;
      int first_rv;
      logic seen;

      vecs[0] = '{OP_ADD, 16'h1234, 16'h0001, 4'd1, 16'h1235, 5'b00000};
      vecs[1] = '{OP_SUB, 16'h0000, 16'h0001, 4'd2, 16'hFFFF, 5'b01010};
      vecs[2] = '{OP_AND, 16'hF0F0, 16'h0F0F, 4'd3, 16'h0000, 5'b00100};
      vecs[3] = '{OP_OR,  16'h8000, 16'h0001, 4'd4, 16'h8001, 5'b00010};
      vecs[4] = '{4'hF,   16'h1111, 16'h2222, 4'hA, 16'h0000, 5'b10000};
      vecs[5] = '{OP_DEC, 16'h0001, 16'h0000, 4'd6, 16'h0000, 5'b00100};
      vecs[6] = '{OP_INC, 16'h7FFF, 16'h0000, 4'd7, 16'h8000, 5'b00011};

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_alu_start", 32'(alu_start), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // ADD latency and flags
      push(OP_ADD, 16'hFFFF, 16'h0001, 4'd3);
      starts = 0;
      first_rv = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (alu_start) starts++;
         if (rsp_valid && first_rv == 0) first_rv = i;
      end
      chk("add_start_cycles", 32'(starts), 32'd3);
      chk("add_rsp_latency", 32'(first_rv), 32'd4);
      chk("add_y", 32'(rsp_y), 32'h0000);
      chk("add_flags", 32'(rsp_flags), 32'b01100);
      chk("add_tag", 32'(rsp_tag), 32'd3);
      ack();

      // invalid opcode bypasses the ALU
      push(4'hC, 16'h1234, 16'h5678, 4'd7);
      starts = 0;
      first_rv = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (alu_start) starts++;
         if (rsp_valid && first_rv == 0) first_rv = i;
      end
      chk("inv_start_cycles", 32'(starts), 32'd0);
      chk("inv_rsp_latency", 32'(first_rv), 32'd1);
      chk("inv_y", 32'(rsp_y), 32'h0000);
      chk("inv_flags", 32'(rsp_flags), 32'b10000);
      chk("inv_tag", 32'(rsp_tag), 32'd7);
      ack();

      // table-driven vectors
      for (int v = 0; v < 7; v++) begin
         push(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag);
         wait_rsp();
         chk("vec_y", 32'(rsp_y), 32'(vecs[v].y));
         chk("vec_flags", 32'(rsp_flags), 32'(vecs[v].fl));
         chk("vec_tag", 32'(rsp_tag), 32'(vecs[v].tag));
         ack();
      end

      // backpressure: one in flight, four queued, sixth offer stalls
      for (int i = 0; i < 5; i++) push(OP_ADD, 16'(i), 16'd1, 4'(i));
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      cmd_valid = 1'b1;
      cmd_opcode = OP_ADD;
      cmd_tag = 4'd5;
      repeat (3) @(negedge clk);
      chk("stall_count", 32'(fifo_count), 32'd4);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_rsp();
         chk("bp_tag", 32'(rsp_tag), 32'(i));
         chk("bp_y", 32'(rsp_y), 32'(i + 1));
         repeat (2) @(negedge clk);
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_tag", 32'(rsp_tag), 32'(i));
         chk("bp_hold_y", 32'(rsp_y), 32'(i + 1));
         ack();
      end

      // push on the same edge as a pop with two queued
      push(OP_ADD, 16'd10, 16'd1, 4'd8);
      push(OP_ADD, 16'd20, 16'd1, 4'd9);
      push(OP_ADD, 16'd30, 16'd1, 4'd10);
      wait_rsp();
      chk("pp_first_tag", 32'(rsp_tag), 32'd8);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("pp_count_before", 32'(fifo_count), 32'd2);
      cmd_valid = 1'b1;
      cmd_opcode = OP_ADD;
      cmd_a = 16'd40;
      cmd_b = 16'd1;
      cmd_tag = 4'd11;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pp_count_after", 32'(fifo_count), 32'd2);
      chk("pp_issued", 32'(alu_start), 32'd1);
      for (int j = 0; j < 3; j++) begin
         wait_rsp();
         chk("pp_tag", 32'(rsp_tag), 32'(9 + j));
         chk("pp_y", 32'(rsp_y), 32'(21 + 10 * j));
         ack();
      end

      // back-to-back with rsp_ready held high
      sq_op[0] = OP_SUB; sq_a[0] = 16'h0005; sq_b[0] = 16'h0003; sq_y[0] = 16'h0002;
      sq_op[1] = OP_XOR; sq_a[1] = 16'hAAAA; sq_b[1] = 16'h5555; sq_y[1] = 16'hFFFF;
      sq_op[2] = OP_NOT; sq_a[2] = 16'h00FF; sq_b[2] = 16'h0000; sq_y[2] = 16'hFF00;
      run_stream(3);

      // ten commands through a four-entry FIFO exercises pointer wrap
      for (int i = 0; i < 10; i++) begin
         sq_op[i] = OP_INC;
         sq_a[i]  = 16'(i * 3);
         sq_b[i]  = 16'h0000;
         sq_y[i]  = 16'(i * 3 + 1);
      end
      run_stream(10);

      // reset during ISSUE with two queued
      push(OP_ADD, 16'd1, 16'd1, 4'd1);
      push(OP_ADD, 16'd2, 16'd2, 4'd2);
      push(OP_ADD, 16'd3, 16'd3, 4'd3);
      chk("rst_pre_start", 32'(alu_start), 32'd1);
      chk("rst_pre_count", 32'(fifo_count), 32'd2);
      reset_n = 1'b0;
      #1;
      chk("arst_alu_start", 32'(alu_start), 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_fifo_count", 32'(fifo_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid || alu_start) seen = 1'b1;
      end
      chk("no_stale_activity", 32'(seen), 32'd0);
      rsp_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
